// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce KEY/SW, qualify selects against a one-hot switch vector
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic       select1,
  output logic       select2,
  output logic       userquit,
  output logic       startpress,
  output logic       badSelect,
  output logic [9:0] swStable,
  output logic       swOneHot,
  output logic [3:0] swIndex
);
  localparam int cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [cnt_w-1:0] key_last = cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [cnt_w-1:0] sw_last = cnt_w'(DEBOUNCE_CYCLES - 2);
  typedef enum logic {RELEASED, PRESSED} key_state_t;
  logic [3:0] key_s1, key_s2, key_evt;
  logic [9:0] sw_s1, sw_s2, sw_prev, sw_next;
  logic [cnt_w-1:0] sw_cnt, sw_cnt_next;
  logic sw_load, oh_next;
  logic [3:0] idx_next;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_key
      key_state_t state, state_next;
      logic [cnt_w-1:0] cnt, cnt_next;
      logic pressed, same, flip, evt;
      always_comb begin
        pressed = ~key_s2[g];
        same = pressed == (state == PRESSED);
        flip = !same && cnt == key_last;
        state_next = flip ? (state == PRESSED ? RELEASED : PRESSED) : state;
        cnt_next = (same || flip) ? '0 : cnt + cnt_w'(1);
      end
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          state <= RELEASED;
          cnt <= '0;
          evt <= 1'b0;
        end else begin
          state <= state_next;
          cnt <= cnt_next;
          evt <= flip && state == RELEASED;
        end
      end
      assign key_evt[g] = evt;
    end
  endgenerate
  always_comb begin
    sw_load = sw_s2 == sw_prev && sw_s2 != swStable && sw_cnt == sw_last;
    sw_cnt_next = (sw_s2 != sw_prev || sw_s2 == swStable || sw_load) ? '0 : sw_cnt + cnt_w'(1);
    sw_next = sw_load ? sw_s2 : swStable;
    oh_next = $onehot(sw_next);
    idx_next = 4'hF;
    for (int i = 0; i < 10; i++) idx_next = (oh_next && sw_next[i]) ? 4'(i) : idx_next;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_prev <= '0;
      sw_cnt <= '0;
      swStable <= '0;
      swOneHot <= 1'b0;
      swIndex <= 4'hF;
      select1 <= 1'b0;
      select2 <= 1'b0;
      userquit <= 1'b0;
      startpress <= 1'b0;
      badSelect <= 1'b0;
    end else begin
      sw_prev <= sw_s2;
      sw_cnt <= sw_cnt_next;
      swStable <= sw_next;
      swOneHot <= oh_next;
      swIndex <= idx_next;
      userquit <= key_evt[2];
      startpress <= key_evt[3] && !key_evt[2];
      select1 <= key_evt[0] && !key_evt[2] && swOneHot;
      select2 <= key_evt[1] && !key_evt[2] && swOneHot;
      badSelect <= (key_evt[0] || key_evt[1]) && !key_evt[2] && !swOneHot;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table-driven and scoreboarded check of input_conditioner
module tb_input_conditioner;
  localparam int D = 4;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic select1, select2, userquit, startpress, badSelect, swOneHot;
  logic [9:0] swStable;
  logic [3:0] swIndex;
  logic [4:0] pv;
  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .SW(SW),
    .select1(select1), .select2(select2), .userquit(userquit),
    .startpress(startpress), .badSelect(badSelect),
    .swStable(swStable), .swOneHot(swOneHot), .swIndex(swIndex)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  assign pv = {badSelect, startpress, userquit, select2, select1};
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  typedef struct {int cyc; logic [4:0] p;} ev_t;
  ev_t sb[$];
  ev_t obs[$];
  always @(negedge CLOCK_50) if (!reset && pv != 5'b0) obs.push_back('{cyc, pv});
  typedef struct {logic [9:0] sw; logic [3:0] keys; logic [4:0] p; logic oh; logic [3:0] idx;} vec_t;
  vec_t tbl[10];
  int tests = 0;
  int fails = 0;
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %h, required %h", name, cyc, got, req);
    end
  endtask
  task automatic expect_pulse(input int at, input logic [4:0] p);
    sb.push_back('{at, p});
  endtask
  task automatic drain(input string name);
    ev_t o, e;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (sb.size() == 0) check({name, "_unexpected_pulse"}, 32'(o.p), 32'd0);
      else begin
        e = sb.pop_front();
        check({name, "_pulse_cyc"}, o.cyc, e.cyc);
        check({name, "_pulse_val"}, 32'(o.p), 32'(e.p));
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_missing_pulse"}, 32'd0, 32'(e.p));
    end
  endtask
  task automatic check_reset_vals(input string name);
    check({name, "_pulses"}, 32'(pv), 32'd0);
    check({name, "_swStable"}, 32'(swStable), 32'd0);
    check({name, "_swOneHot"}, 32'(swOneHot), 32'd0);
    check({name, "_swIndex"}, 32'(swIndex), 32'hF);
  endtask
  initial begin
    logic [9:0] prev_sw;
    logic prev_oh;
    logic [3:0] prev_idx;
    int n;
    tbl[0] = '{10'h008, 4'b0001, 5'b00001, 1'b1, 4'd3};
    tbl[1] = '{10'h008, 4'b0010, 5'b00010, 1'b1, 4'd3};
    tbl[2] = '{10'h003, 4'b0001, 5'b10000, 1'b0, 4'hF};
    tbl[3] = '{10'h000, 4'b0001, 5'b10000, 1'b0, 4'hF};
    tbl[4] = '{10'h200, 4'b0101, 5'b00100, 1'b1, 4'd9};
    tbl[5] = '{10'h200, 4'b1000, 5'b01000, 1'b1, 4'd9};
    tbl[6] = '{10'h001, 4'b0011, 5'b00011, 1'b1, 4'd0};
    tbl[7] = '{10'h0C0, 4'b0011, 5'b10000, 1'b0, 4'hF};
    tbl[8] = '{10'h100, 4'b1100, 5'b00100, 1'b1, 4'd8};
    tbl[9] = '{10'h3FF, 4'b0010, 5'b10000, 1'b0, 4'hF};
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(5);
    prev_sw = '0;
    prev_oh = 1'b0;
    prev_idx = 4'hF;
    for (int i = 0; i < 10; i++) begin
      SW = tbl[i].sw;
      tick(5);
      check($sformatf("v%0d_swStable_before", i), 32'(swStable), 32'(prev_sw));
      tick(1);
      check($sformatf("v%0d_swStable", i), 32'(swStable), 32'(tbl[i].sw));
      check($sformatf("v%0d_swOneHot", i), 32'(swOneHot), 32'(tbl[i].oh));
      check($sformatf("v%0d_swIndex", i), 32'(swIndex), 32'(tbl[i].idx));
      prev_sw = tbl[i].sw;
      prev_oh = tbl[i].oh;
      prev_idx = tbl[i].idx;
      tick(4);
      KEY = ~tbl[i].keys;
      expect_pulse(cyc + 7, tbl[i].p);
      tick(20);
      KEY = 4'hF;
      tick(10);
      drain($sformatf("v%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      KEY[1] = ~KEY[1];
      tick(2);
    end
    KEY = 4'hF;
    tick(10);
    check("bounce_quiet", obs.size(), 0);
    drain("bounce");
    KEY = 4'h7;
    expect_pulse(cyc + 7, 5'b01000);
    tick(100);
    KEY = 4'hF;
    tick(10);
    KEY = 4'h7;
    expect_pulse(cyc + 7, 5'b01000);
    tick(20);
    KEY = 4'hF;
    tick(10);
    drain("hold");
    SW = 10'h008;
    tick(10);
    KEY = 4'hE;
    tick(3);
    reset = 1'b1;
    n = cyc;
    tick(1);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    expect_pulse(n + 8, 5'b00001);
    tick(20);
    KEY = 4'hF;
    tick(10);
    drain("mid_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
